// File: rtl/alu_packet_engine.sv
// Packet-parsing compute stage: echoes payload or returns a 32-bit sum/product of
// little-endian operand words, streamed back one byte at a time.
module alu_packet_engine #(
  parameter logic [7:0] opcode_echo_p = 8'hEC,
  parameter logic [7:0] opcode_add_p  = 8'hA0,
  parameter logic [7:0] opcode_mul_p  = 8'hB1
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       err_o
);

  typedef enum logic [2:0] {StHdr, StEcho, StOper, StResult, StDrain} state_e;

  state_e      state_q;
  logic [1:0]  hdr_cnt_q;
  logic [7:0]  opcode_q;
  logic [7:0]  len_lo_q;
  logic [15:0] rem_q;
  logic [1:0]  byte_idx_q;
  logic [23:0] word_q;
  logic        first_q;
  logic [31:0] acc_q;
  logic [2:0]  res_cnt_q;
  logic [7:0]  m_data_q;
  logic        m_valid_q;
  logic        err_q;

  logic        out_loadable;
  logic        s_fire;
  logic [15:0] hdr_len;
  logic        is_echo;
  logic        is_arith;
  logic        len_ok;
  logic [31:0] word;
  logic [31:0] sum;
  logic [31:0] prod;
  logic [31:0] acc_new;
  logic [7:0]  res_byte;

  assign out_loadable = !m_valid_q || m_axis_tready;
  assign s_fire       = s_axis_tvalid && s_axis_tready;
  assign hdr_len      = {s_axis_tdata, len_lo_q};
  assign is_echo      = (opcode_q == opcode_echo_p);
  assign is_arith     = (opcode_q == opcode_add_p) || (opcode_q == opcode_mul_p);
  // Payload must hold at least one whole word and only whole words.
  assign len_ok       = (hdr_len >= 16'd8) && (hdr_len[1:0] == 2'b00);
  assign word         = {s_axis_tdata, word_q};
  assign sum          = acc_q + word;
  assign prod         = acc_q * word;

  always_comb begin
    acc_new = word;
    if (!first_q) begin
      acc_new = (opcode_q == opcode_add_p) ? sum : prod;
    end
  end

  always_comb begin
    res_byte = acc_q[7:0];
    unique case (res_cnt_q[1:0])
      2'd0: res_byte = acc_q[7:0];
      2'd1: res_byte = acc_q[15:8];
      2'd2: res_byte = acc_q[23:16];
      2'd3: res_byte = acc_q[31:24];
      default: res_byte = acc_q[7:0];
    endcase
  end

  always_comb begin
    s_axis_tready = 1'b0;
    if (reset_n_i) begin
      unique case (state_q)
        StHdr:    s_axis_tready = 1'b1;
        StEcho:   s_axis_tready = out_loadable;
        StOper:   s_axis_tready = 1'b1;
        StResult: s_axis_tready = 1'b0;
        StDrain:  s_axis_tready = 1'b1;
        default:  s_axis_tready = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q    <= StHdr;
      hdr_cnt_q  <= 2'd0;
      opcode_q   <= 8'd0;
      len_lo_q   <= 8'd0;
      rem_q      <= 16'd0;
      byte_idx_q <= 2'd0;
      word_q     <= 24'd0;
      first_q    <= 1'b1;
      acc_q      <= 32'd0;
      res_cnt_q  <= 3'd0;
      m_data_q   <= 8'd0;
      m_valid_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (m_valid_q && m_axis_tready) begin
        m_valid_q <= 1'b0;
      end

      unique case (state_q)
        StHdr: begin
          if (s_fire) begin
            hdr_cnt_q <= hdr_cnt_q + 2'd1;
            unique case (hdr_cnt_q)
              2'd0: opcode_q <= s_axis_tdata;
              2'd1: ;
              2'd2: len_lo_q <= s_axis_tdata;
              2'd3: begin
                rem_q      <= hdr_len - 16'd4;
                byte_idx_q <= 2'd0;
                first_q    <= 1'b1;
                if (is_echo) begin
                  state_q <= (hdr_len > 16'd4) ? StEcho : StHdr;
                end else if (is_arith && len_ok) begin
                  state_q <= StOper;
                end else begin
                  err_q   <= 1'b1;
                  state_q <= (hdr_len > 16'd4) ? StDrain : StHdr;
                end
              end
              default: ;
            endcase
          end
        end

        StEcho: begin
          if (s_fire) begin
            m_data_q  <= s_axis_tdata;
            m_valid_q <= 1'b1;
            rem_q     <= rem_q - 16'd1;
            if (rem_q == 16'd1) begin
              state_q <= StHdr;
            end
          end
        end

        StOper: begin
          if (s_fire) begin
            byte_idx_q <= byte_idx_q + 2'd1;
            word_q     <= {s_axis_tdata, word_q[23:8]};
            rem_q      <= rem_q - 16'd1;
            if (byte_idx_q == 2'd3) begin
              acc_q   <= acc_new;
              first_q <= 1'b0;
              if (rem_q == 16'd1) begin
                state_q <= StResult;
                // Emit the low byte right away unless a previous byte is still stalled.
                if (out_loadable) begin
                  m_data_q  <= acc_new[7:0];
                  m_valid_q <= 1'b1;
                  res_cnt_q <= 3'd1;
                end else begin
                  res_cnt_q <= 3'd0;
                end
              end
            end
          end
        end

        StResult: begin
          if (out_loadable) begin
            if (res_cnt_q < 3'd4) begin
              m_data_q  <= res_byte;
              m_valid_q <= 1'b1;
              res_cnt_q <= res_cnt_q + 3'd1;
            end else begin
              state_q <= StHdr;
            end
          end
        end

        StDrain: begin
          if (s_fire) begin
            rem_q <= rem_q - 16'd1;
            if (rem_q == 16'd1) begin
              state_q <= StHdr;
            end
          end
        end

        default: state_q <= StHdr;
      endcase
    end
  end

  assign m_axis_tdata  = m_data_q;
  assign m_axis_tvalid = m_valid_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_alu_packet_engine.sv
// Directed bench for alu_packet_engine: arithmetic, echo under backpressure,
// malformed packets and reset in the middle of a result.
module tb_alu_packet_engine;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready;
  logic       err;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] got[$];
  int         err_cnt = 0;
  int         stall_viol = 0;
  logic       toggle_en = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'd0;

  alu_packet_engine dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  // Inputs only change at posedge+1, so the negedge view is what the next edge sees.
  always @(negedge clk) begin
    if (m_tvalid && m_tready) got.push_back(m_tdata);
    if (err) err_cnt++;
    if (prev_stall && (!m_tvalid || m_tdata !== prev_data)) stall_viol++;
    prev_stall = m_tvalid && !m_tready;
    prev_data  = m_tdata;
  end

  always @(posedge clk) begin
    if (toggle_en) begin
      #1 m_tready = ~m_tready;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    logic ok;
    int   n;
    n = 0;
    s_tdata  = b;
    s_tvalid = 1'b1;
    do begin
      @(negedge clk);
      ok = s_tready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    s_tvalid = 1'b0;
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL send_byte: byte %h not accepted within 200 cycles (accepted=%0b, required 1)",
               b, ok);
    end
  endtask

  task automatic send_pkt(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i]);
  endtask

  task automatic wait_out(input int n);
    int cyc;
    cyc = 0;
    while (got.size() < n && cyc < 500) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    compared++;
    if (got.size() < n) begin
      mismatched++;
      $display("FAIL wait_out: got %0d bytes, required %0d", got.size(), n);
    end
  endtask

  task automatic check_out(input string name, input logic [7:0] exp[$]);
    repeat (5) @(posedge clk);
    #1;
    compared++;
    if (got.size() != exp.size()) begin
      mismatched++;
      $display("FAIL %s count: got %0d bytes, required %0d", name, got.size(), exp.size());
    end
    foreach (exp[i]) begin
      if (i < got.size()) begin
        compared++;
        if (got[i] !== exp[i]) begin
          mismatched++;
          $display("FAIL %s byte%0d: got %h, required %h", name, i, got[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = 8'd0;
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compared += 4;
    if (m_tvalid !== 1'b0) begin
      mismatched++; $display("FAIL reset_tvalid: got %b, required 0", m_tvalid);
    end
    if (m_tdata !== 8'h00) begin
      mismatched++; $display("FAIL reset_tdata: got %h, required 00", m_tdata);
    end
    if (err !== 1'b0) begin
      mismatched++; $display("FAIL reset_err: got %b, required 0", err);
    end
    if (s_tready !== 1'b0) begin
      mismatched++; $display("FAIL reset_tready: got %b, required 0", s_tready);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_add();
    int e0;
    e0 = err_cnt;
    got.delete();
    send_pkt('{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00,
               8'h07, 8'h00, 8'h00, 8'h00});
    wait_out(4);
    check_out("add", '{8'h0C, 8'h00, 8'h00, 8'h00});
    compared++;
    if (err_cnt != e0) begin
      mismatched++; $display("FAIL add_err: got %0d pulses, required 0", err_cnt - e0);
    end
  endtask

  task automatic test_add_wrap();
    got.delete();
    send_pkt('{8'hA0, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
               8'h03, 8'h00, 8'h00, 8'h00});
    wait_out(4);
    check_out("add_wrap", '{8'h02, 8'h00, 8'h00, 8'h00});
  endtask

  task automatic test_mul();
    got.delete();
    send_pkt('{8'hB1, 8'h00, 8'h10, 8'h00, 8'h06, 8'h00, 8'h00, 8'h00,
               8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01});
    wait_out(4);
    check_out("mul", '{8'h00, 8'h00, 8'h00, 8'h2A});
  endtask

  task automatic test_echo_backpressure();
    got.delete();
    stall_viol = 0;
    toggle_en = 1'b1;
    send_pkt('{8'hEC, 8'h00, 8'h07, 8'h00, 8'h11, 8'h22, 8'h33});
    wait_out(3);
    check_out("echo", '{8'h11, 8'h22, 8'h33});
    toggle_en = 1'b0;
    @(posedge clk);
    #2;
    m_tready = 1'b1;
    compared++;
    if (stall_viol != 0) begin
      mismatched++; $display("FAIL echo_stable: got %0d violations, required 0", stall_viol);
    end
  endtask

  task automatic test_malformed(input logic [7:0] hdr[$], input logic [7:0] pay[$],
                                input string name);
    int e0;
    e0 = err_cnt;
    got.delete();
    send_pkt(hdr);
    compared++;
    if (err !== 1'b1) begin
      mismatched++; $display("FAIL %s err_pulse: got %b, required 1", name, err);
    end
    send_pkt(pay);
    send_pkt('{8'hA0, 8'h00, 8'h08, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00});
    wait_out(4);
    check_out(name, '{8'h01, 8'h00, 8'h00, 8'h00});
    compared++;
    if (err_cnt - e0 != 1) begin
      mismatched++; $display("FAIL %s err_count: got %0d, required 1", name, err_cnt - e0);
    end
  endtask

  task automatic test_reset_mid_result();
    int cyc;
    got.delete();
    m_tready = 1'b0;
    send_pkt('{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00,
               8'h07, 8'h00, 8'h00, 8'h00});
    cyc = 0;
    while (!m_tvalid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_tready = 1'b0;
    reset_n  = 1'b0;
    @(posedge clk);
    #1;
    compared++;
    if (m_tvalid !== 1'b0) begin
      mismatched++; $display("FAIL rst_mid_tvalid0: got %b, required 0", m_tvalid);
    end
    m_tready = 1'b1;
    @(posedge clk);
    #1;
    compared++;
    if (m_tvalid !== 1'b0) begin
      mismatched++; $display("FAIL rst_mid_tvalid1: got %b, required 0", m_tvalid);
    end
    reset_n = 1'b1;
    check_out("rst_partial", '{8'h0C, 8'h00});
    got.delete();
    send_pkt('{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
               8'h02, 8'h00, 8'h00, 8'h00});
    wait_out(4);
    check_out("rst_fresh", '{8'h03, 8'h00, 8'h00, 8'h00});
  endtask

  initial begin
    test_reset();
    test_add();
    test_add_wrap();
    test_mul();
    test_echo_backpressure();
    test_malformed('{8'hA0, 8'h00, 8'h06, 8'h00}, '{8'hAA, 8'hBB}, "bad_len");
    test_malformed('{8'h55, 8'h00, 8'h05, 8'h00}, '{8'h99}, "bad_op");
    test_reset_mid_result();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
